// File: rtl/step_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// step_ctrl_pkg
// Shared definitions for the single-step / auto-step controller.
//   state_t           : controller mode, MANUAL (push-button stepping) or
//                       AUTO (free-running stepping at a selectable rate)
//   DEFAULT_DB_CYCLES : default debounce length in clk cycles (10 ms @ 50 MHz)
//   DEFAULT_AUTO_DIV  : default base auto-step period in clk cycles
//                       (0.5 s @ 50 MHz)
//   auto_period()     : auto-step period for a given rate select
// ---------------------------------------------------------------------------
package step_ctrl_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    localparam int DEFAULT_DB_CYCLES = 500_000;
    localparam int DEFAULT_AUTO_DIV  = 25_000_000;

    // Rate 0 is the slowest (full base period), each increment halves it.
    function automatic int auto_period(input int base, input logic [1:0] rate);
        return base >>> rate;
    endfunction

endpackage

// File: rtl/step_ctrl_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Conditions one raw active-low push-button into a single-cycle press pulse.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   key_n  : raw button level, active-low, asynchronous to clk
//   press  : one-cycle pulse, high the cycle after the debounced level
//            falls (button pressed); releases produce nothing
// The raw level is brought into the clk domain by two flops, then a counter
// requires DB_CYCLES consecutive cycles of disagreement with the accepted
// level before the accepted level follows. Any cycle of agreement (a
// bounce back) restarts the count.
// ---------------------------------------------------------------------------
module key_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] db_cnt;
    logic             level;
    logic             level_prev;

    // Two-flop synchronizer; resets to the released (high) level so that a
    // reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    // Debounce counter: counts consecutive cycles in which the synchronized
    // input disagrees with the accepted level; the level flips on the
    // DB_CYCLES-th such cycle and the count starts over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b1;
        end else if (sync_b != level) begin
            if (db_cnt == CNT_LAST) begin
                db_cnt <= '0;
                level  <= sync_b;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Falling-edge detector on the accepted level. Registering against the
    // previous level puts the pulse one cycle after the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev <= 1'b1;
            press      <= 1'b0;
        end else begin
            level_prev <= level;
            press      <= level_prev & ~level;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// ---------------------------------------------------------------------------
// step_ctrl
// Step controller for a datapath under test: issues single-cycle advance
// strobes either on a push-button (MANUAL) or periodically (AUTO).
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset (deassert synchronously)
//   key_step_n : raw step button, active-low
//   key_mode_n : raw mode button, active-low, toggles MANUAL/AUTO
//   sw_rate    : auto-step rate, period = AUTO_DIV >> sw_rate (0 slowest)
//   step       : one-cycle advance strobe
//   wrap       : one-cycle strobe on the step that takes step_cnt 15 -> 0
//   auto_mode  : high while in AUTO
//   step_cnt   : number of steps issued, modulo 16
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int AUTO_DIV  = DEFAULT_AUTO_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_step_n,
    input  logic       key_mode_n,
    input  logic [1:0] sw_rate,
    output logic       step,
    output logic       wrap,
    output logic       auto_mode,
    output logic [3:0] step_cnt
);

    localparam int TICK_W = $clog2(AUTO_DIV + 1);

    logic              step_press;
    logic              mode_press;

    state_t            state_q;
    state_t            state_d;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic [TICK_W-1:0] period_q;
    logic [TICK_W-1:0] period_d;
    logic [TICK_W-1:0] rate_period;
    logic              tick_last;
    logic              step_d;
    logic              wrap_d;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_step (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_step_n),
        .press (step_press)
    );

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_mode_n),
        .press (mode_press)
    );

    // The period in force is latched only on AUTO entry and at each
    // rollover, so a rate change never cuts short the period in progress.
    assign rate_period = TICK_W'(auto_period(AUTO_DIV, sw_rate));
    assign tick_last   = (tick_q == period_q - TICK_W'(1));

    // State register plus the auto-step tick counter and its latched period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MANUAL;
            tick_q   <= '0;
            period_q <= TICK_W'(AUTO_DIV);
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            period_q <= period_d;
        end
    end

    // Next-state and step decision. A mode press always wins over a step
    // event in the same cycle: the mode changes and the step is dropped.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        period_d = period_q;
        step_d   = 1'b0;
        unique case (state_q)
            MANUAL: begin
                if (mode_press) begin
                    state_d  = AUTO;
                    tick_d   = '0;
                    period_d = rate_period;
                end else if (step_press) begin
                    step_d = 1'b1;
                end
            end
            AUTO: begin
                if (mode_press) begin
                    state_d = MANUAL;
                end else if (tick_last) begin
                    step_d   = 1'b1;
                    tick_d   = '0;
                    period_d = rate_period;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = MANUAL;
            end
        endcase
    end

    assign wrap_d = step_d && (step_cnt == 4'hF);

    // Registered outputs; step_cnt and wrap update on the same edge that
    // raises step so all three line up on the display side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step      <= 1'b0;
            wrap      <= 1'b0;
            auto_mode <= 1'b0;
            step_cnt  <= 4'h0;
        end else begin
            step      <= step_d;
            wrap      <= wrap_d;
            auto_mode <= (state_d == AUTO);
            if (step_d) begin
                step_cnt <= step_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_step_ctrl
// Directed scenarios followed by a randomized key/rate phase. A behavioural
// model predicts step/wrap/auto_mode/step_cnt every cycle: the debounced
// key level is derived from a window over the raw key history, and AUTO
// stepping from a scheduled "next step at cycle N" time.
// ---------------------------------------------------------------------------
module tb_step_ctrl;

    localparam int DB   = 4;
    localparam int AD   = 16;
    localparam int MAXN = 16384;

    logic       clk;
    logic       rst_n;
    logic       key_step_n;
    logic       key_mode_n;
    logic [1:0] sw_rate;
    logic       step;
    logic       wrap;
    logic       auto_mode;
    logic [3:0] step_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: raw key values seen at each edge since reset, the
    // debounced level after each edge, mode flag, step count, next auto step.
    bit raw_s [MAXN];
    bit raw_m [MAXN];
    bit lvl_s [MAXN];
    bit lvl_m [MAXN];
    int n;
    bit m_auto;
    int m_cnt;
    int m_next;
    bit exp_step;
    bit exp_wrap;

    // Observation bookkeeping for directed checks.
    int edge_abs       = 0;
    int steps_seen     = 0;
    int wrap_count     = 0;
    int wrap_at        = 0;
    int auto_rise_edge = 0;
    bit prev_auto      = 1'b0;
    int step_edges[$];

    step_ctrl #(
        .DB_CYCLES (DB),
        .AUTO_DIV  (AD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_step_n (key_step_n),
        .key_mode_n (key_mode_n),
        .sw_rate    (sw_rate),
        .step       (step),
        .wrap       (wrap),
        .auto_mode  (auto_mode),
        .step_cnt   (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit rawAt(input bit sel, input int i);
        if (i < 0) return 1'b1;
        return sel ? raw_m[i] : raw_s[i];
    endfunction

    function automatic bit lvlAt(input bit sel, input int i);
        if (i < 0) return 1'b1;
        return sel ? lvl_m[i] : lvl_s[i];
    endfunction

    // The accepted level flips once the last DB synchronized samples all
    // disagree with it; the synchronizer delays raw input by two edges.
    function automatic bit newLevel(input bit sel);
        bit old_lvl;
        bit all_diff;
        old_lvl  = lvlAt(sel, n - 1);
        all_diff = 1'b1;
        for (int k = n - DB - 1; k <= n - 2; k++) begin
            if (rawAt(sel, k) == old_lvl) all_diff = 1'b0;
        end
        return all_diff ? !old_lvl : old_lvl;
    endfunction

    // Press pulse visible before edge n: level fell at edge n-2.
    function automatic bit pressPrev(input bit sel);
        return lvlAt(sel, n - 3) && !lvlAt(sel, n - 2);
    endfunction

    task automatic modelReset();
        n        = 0;
        m_auto   = 1'b0;
        m_cnt    = 0;
        m_next   = 0;
        exp_step = 1'b0;
        exp_wrap = 1'b0;
    endtask

    task automatic modelEdge(input bit s_n, input bit m_n, input logic [1:0] r);
        bit mode_evt;
        bit step_evt;
        if (n >= MAXN) begin
            $display("[TB] FAIL model_overflow observed=%0d required<%0d", n, MAXN);
            $fatal(1, "[TB] model overflow");
        end
        raw_s[n] = s_n;
        raw_m[n] = m_n;
        lvl_s[n] = newLevel(1'b0);
        lvl_m[n] = newLevel(1'b1);
        mode_evt = pressPrev(1'b1);
        step_evt = m_auto ? (n == m_next) : pressPrev(1'b0);
        exp_step = 1'b0;
        exp_wrap = 1'b0;
        if (mode_evt) begin
            m_auto = !m_auto;
            if (m_auto) m_next = n + (AD >> r);
        end else if (step_evt) begin
            exp_step = 1'b1;
            m_cnt    = (m_cnt + 1) % 16;
            exp_wrap = (m_cnt == 0);
            if (m_auto) m_next = n + (AD >> r);
        end
        n++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, then compare the
    // registered outputs against the model.
    task automatic applyStimulus(input bit s_n, input bit m_n, input logic [1:0] r);
        key_step_n = s_n;
        key_mode_n = m_n;
        sw_rate    = r;
        @(posedge clk);
        #1;
        edge_abs++;
        modelEdge(s_n, m_n, r);
        checkOutput("step", 32'(step), 32'(exp_step));
        checkOutput("wrap", 32'(wrap), 32'(exp_wrap));
        checkOutput("auto_mode", 32'(auto_mode), 32'(m_auto));
        checkOutput("step_cnt", 32'(step_cnt), 32'(m_cnt));
        if (step === 1'b1) begin
            steps_seen++;
            step_edges.push_back(edge_abs);
            if (wrap === 1'b1) begin
                wrap_count++;
                wrap_at = steps_seen;
            end
        end
        if (auto_mode === 1'b1 && !prev_auto) auto_rise_edge = edge_abs;
        prev_auto = (auto_mode === 1'b1);
    endtask

    task automatic pressKeys(input bit on_step, input bit on_mode, input int low_cycles,
                             input int high_cycles, input logic [1:0] r);
        for (int i = 0; i < low_cycles; i++) applyStimulus(!on_step, !on_mode, r);
        for (int i = 0; i < high_cycles; i++) applyStimulus(1'b1, 1'b1, r);
    endtask

    task automatic resetDut();
        key_step_n = 1'b1;
        key_mode_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_step", 32'(step), 32'd0);
        checkOutput("reset_auto", 32'(auto_mode), 32'd0);
        checkOutput("reset_cnt", 32'(step_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        prev_auto = 1'b0;
    endtask

    initial begin
        bit         rs;
        bit         rm;
        logic [1:0] rr;
        int         snap_cnt;
        int         budget;
        bit         bounce_pat [10];

        rst_n      = 1'b1;
        key_step_n = 1'b1;
        key_mode_n = 1'b1;
        sw_rate    = 2'd0;
        modelReset();

        // Power-on reset: outputs must clear asynchronously, before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("por_step", 32'(step), 32'd0);
        checkOutput("por_wrap", 32'(wrap), 32'd0);
        checkOutput("por_auto", 32'(auto_mode), 32'd0);
        checkOutput("por_cnt", 32'(step_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Bouncy step press: low for 10 cycles with two early bounces.
        bounce_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        steps_seen = 0;
        for (int i = 0; i < 10; i++) applyStimulus(bounce_pat[i], 1'b1, 2'd0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 2'd0);
        checkOutput("bounce_steps", 32'(steps_seen), 32'd1);
        checkOutput("bounce_cnt", 32'(step_cnt), 32'd1);

        // Sixteen clean presses from zero: count wraps back to zero and wrap
        // appears only on the sixteenth step.
        resetDut();
        steps_seen = 0;
        wrap_count = 0;
        wrap_at    = 0;
        for (int i = 0; i < 16; i++) pressKeys(1'b1, 1'b0, 6, 8, 2'd0);
        checkOutput("sixteen_steps", 32'(steps_seen), 32'd16);
        checkOutput("sixteen_wraps", 32'(wrap_count), 32'd1);
        checkOutput("sixteen_wrap_at", 32'(wrap_at), 32'd16);
        checkOutput("sixteen_cnt", 32'(step_cnt), 32'd0);

        // AUTO at rate 2: first step 4 cycles after entry, then every 4,
        // with a step press in the middle that must not disturb spacing.
        step_edges.delete();
        pressKeys(1'b0, 1'b1, 6, 14, 2'd2);
        pressKeys(1'b1, 1'b0, 6, 20, 2'd2);
        checkOutput("auto_on", 32'(auto_mode), 32'd1);
        if (step_edges.size() < 8) begin
            checkOutput("auto_step_count", 32'(step_edges.size()), 32'd8);
        end else begin
            checkOutput("auto_first_gap", 32'(step_edges[0] - auto_rise_edge), 32'd4);
            for (int i = 1; i < step_edges.size(); i++)
                checkOutput("auto_gap", 32'(step_edges[i] - step_edges[i-1]), 32'd4);
        end
        pressKeys(1'b0, 1'b1, 6, 6, 2'd2);
        checkOutput("auto_off", 32'(auto_mode), 32'd0);

        // Mode and step pressed together in MANUAL: mode wins, no step.
        snap_cnt   = m_cnt;
        steps_seen = 0;
        pressKeys(1'b1, 1'b1, 6, 4, 2'd0);
        checkOutput("both_auto", 32'(auto_mode), 32'd1);
        checkOutput("both_steps", 32'(steps_seen), 32'd0);
        checkOutput("both_cnt", 32'(step_cnt), 32'(snap_cnt));

        // Run AUTO until the count reaches 7, then reset mid-cycle.
        budget = 400;
        do begin
            applyStimulus(1'b1, 1'b1, 2'd2);
            budget--;
        end while (!(m_cnt == 7 && exp_step) && budget > 0);
        checkOutput("reach_cnt7", 32'(step_cnt), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_step", 32'(step), 32'd0);
        checkOutput("midrst_wrap", 32'(wrap), 32'd0);
        checkOutput("midrst_auto", 32'(auto_mode), 32'd0);
        checkOutput("midrst_cnt", 32'(step_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        prev_auto  = 1'b0;
        steps_seen = 0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 2'd2);
        checkOutput("post_rst_idle", 32'(steps_seen), 32'd0);
        pressKeys(1'b1, 1'b0, 6, 6, 2'd2);
        checkOutput("post_rst_press", 32'(steps_seen), 32'd1);
        checkOutput("post_rst_cnt", 32'(step_cnt), 32'd1);

        // Randomized keys and rate, every cycle checked against the model.
        rs = 1'b1;
        rm = 1'b1;
        rr = 2'd1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)  rs = !rs;
            if ($urandom_range(0, 15) == 0) rm = !rm;
            if ($urandom_range(0, 99) == 0) rr = 2'($urandom_range(0, 3));
            applyStimulus(rs, rm, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
